// File: rtl/commit_trace_unit_pkg.sv
// Shared types for the commit trace path: commit record, ebreak encoding, drain FSM states.
// No logic; record fields are sized for the widest supported XLEN.
package npc_trace_pkg;

  localparam int TR_XLEN = 64;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

  typedef struct packed {
    logic [TR_XLEN-1:0] pc;
    logic [31:0]        inst;
    logic               wen;
    logic [4:0]         rd;
    logic [TR_XLEN-1:0] wdata;
  } commit_rec_t;

  typedef enum logic [1:0] {
    TR_RUN   = 2'd0,
    TR_DRAIN = 2'd1,
    TR_HALT  = 2'd2
  } tr_state_e;

  function automatic logic is_ebreak(input logic [31:0] inst);
    return inst == INST_EBREAK;
  endfunction

endpackage

// File: rtl/commit_trace_unit_if.sv
// Write-back capture and commit delivery bundle; master is the trace unit, slave the environment.
// Record handshake is valid/ready (cm_*); write-back backpressure is wb_stall.
interface commit_trace_unit_if #(parameter int XLEN = 64);

  logic              wb_valid;
  logic [XLEN-1:0]   wb_pc;
  logic [31:0]       wb_inst;
  logic              wb_rf_wen;
  logic [4:0]        wb_rd;
  logic [XLEN-1:0]   wb_rf_wdata;
  logic              wb_stall;

  logic              cm_valid;
  logic              cm_ready;
  logic [XLEN-1:0]   cm_pc;
  logic [31:0]       cm_inst;
  logic [32*XLEN-1:0] cm_gpr;

  logic              halt;
  logic [63:0]       commit_cnt;
  logic [63:0]       cycle_cnt;

  modport master (
    input  wb_valid, wb_pc, wb_inst, wb_rf_wen, wb_rd, wb_rf_wdata, cm_ready,
    output wb_stall, cm_valid, cm_pc, cm_inst, cm_gpr, halt, commit_cnt, cycle_cnt
  );

  modport slave (
    output wb_valid, wb_pc, wb_inst, wb_rf_wen, wb_rd, wb_rf_wdata, cm_ready,
    input  wb_stall, cm_valid, cm_pc, cm_inst, cm_gpr, halt, commit_cnt, cycle_cnt
  );

endinterface

// File: rtl/commit_trace_unit_fifo.sv
// Generic synchronous FIFO, 1-cycle push-to-visible latency, head read combinationally.
// Caller must not push when full or pop when empty; no pass-through when full.
module trace_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  T     push_dat,
  input  logic pop,
  output T     pop_dat,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  // Extra MSB is the wrap bit that separates full from empty.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  T            mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

  assign pop_dat = mem[rd_ptr[AW-1:0]];
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign empty   = (wr_ptr == rd_ptr);

endmodule

// File: rtl/commit_trace_unit.sv
// Queues retired instructions and delivers them with a shadow GPR file; push-to-cm_valid 1 cycle.
// wb_stall when full, draining after ebreak, or halted; cm_ready only gates pops.
module commit_trace_unit
  import npc_trace_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 64
) (
  input logic                 clk,
  input logic                 rst,
  commit_trace_unit_if.master bus
);

  tr_state_e   state;
  tr_state_e   state_nxt;
  commit_rec_t push_rec;
  commit_rec_t head_rec;
  logic        push;
  logic        pop;
  logic        full;
  logic        empty;
  logic [XLEN-1:0] shadow [32];

  assign push = bus.wb_valid & ~bus.wb_stall;
  assign pop  = bus.cm_valid & bus.cm_ready;

  always_comb begin
    push_rec       = '0;
    push_rec.pc    = TR_XLEN'(bus.wb_pc);
    push_rec.inst  = bus.wb_inst;
    push_rec.wen   = bus.wb_rf_wen;
    push_rec.rd    = bus.wb_rd;
    push_rec.wdata = TR_XLEN'(bus.wb_rf_wdata);
  end

  trace_fifo #(
    .DEPTH (DEPTH),
    .T     (commit_rec_t)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (push_rec),
    .pop      (pop),
    .pop_dat  (head_rec),
    .full     (full),
    .empty    (empty)
  );

  assign bus.cm_valid = ~empty;
  assign bus.cm_pc    = XLEN'(head_rec.pc);
  assign bus.cm_inst  = head_rec.inst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= TR_RUN;
    else     state <= state_nxt;
  end

  // Outputs depend only on registered state so wb_stall has no path from wb_valid/cm_ready.
  always_comb begin
    state_nxt    = state;
    bus.wb_stall = 1'b1;
    bus.halt     = 1'b0;
    case (state)
      TR_RUN: begin
        bus.wb_stall = full;
        if (bus.wb_valid && !full && is_ebreak(bus.wb_inst)) state_nxt = TR_DRAIN;
      end
      TR_DRAIN: begin
        // The ebreak is the last queued record, so popping it empties the FIFO.
        if (empty || (pop && is_ebreak(head_rec.inst))) state_nxt = TR_HALT;
      end
      TR_HALT: begin
        bus.halt = 1'b1;
      end
      default: state_nxt = TR_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.commit_cnt <= '0;
      bus.cycle_cnt  <= '0;
      for (int i = 0; i < 32; i++) shadow[i] <= '0;
    end else begin
      if (state != TR_HALT) bus.cycle_cnt <= bus.cycle_cnt + 64'd1;
      if (pop) begin
        bus.commit_cnt <= bus.commit_cnt + 64'd1;
        if (head_rec.wen && head_rec.rd != 5'd0) shadow[head_rec.rd] <= XLEN'(head_rec.wdata);
      end
    end
  end

  always_comb begin
    bus.cm_gpr = '0;
    for (int i = 0; i < 32; i++) bus.cm_gpr[i*XLEN +: XLEN] = shadow[i];
  end

endmodule
